shader_loader: RTL and testbench
================================

Name: shader_loader

Overview:
- Host-side initiator for the shader core's load/run interface.
- Consumes a valid/ready stream of 32-bit command and payload words and writes them into the core's instruction and data RAMs through the core's external write port.
- On command, resets the core, starts it, and waits for halted or a timeout.
- Reports completion, timeout and run-cycle count to the host.

Parameters:
- ADDRESS_WIDTH, 16, byte-address width of the core's external write port.
- WORD_WIDTH, 32, stream and RAM word width.
- COUNT_WIDTH, 14, payload word-count field width.
- CORE_RESET_CYCLES, 2, cycles core_reset_n is held low before run (≥1).
- MAX_RUN_CYCLES, 1000000, run timeout in cycles; 0 disables the timeout.

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  stream word valid.
- in_data  in  WORD_WIDTH  stream word.
- in_ready  out  1  loader accepts in_data this cycle.
- core_reset_n  out  1  synchronous active-low reset to the core.
- run  out  1  core run enable.
- halted  in  1  core halted flag.
- ext_write_address  out  ADDRESS_WIDTH  byte address to the core.
- ext_write_data  out  WORD_WIDTH  write data to the core.
- ext_enable_write_inst  out  1  one-cycle instruction-RAM write strobe.
- ext_enable_write_data  out  1  one-cycle data-RAM write strobe.
- busy  out  1  not in IDLE.
- done  out  1  one-cycle pulse when a RUN command completes.
- timed_out  out  1  last run ended by timeout.
- bad_cmd  out  1  one-cycle pulse on a reserved header.
- run_cycles  out  32  cycles run was high in the last run.

Behaviour:
- Handshake: a word transfers when in_valid && in_ready. in_ready = 1 in IDLE and WRITE, 0 otherwise.
- All outputs are registered.
- Header word fields: [31:30] type (00 INST, 01 DATA, 10 RUN, 11 reserved); [29:16] count; [15:0] start byte address (low 2 bits ignored, forced to 0).
- Reset values: state IDLE; core_reset_n=0; run=0; both write strobes=0; ext_write_address=0; ext_write_data=0; busy=0; done=0; timed_out=0; bad_cmd=0; run_cycles=0.
- core_reset_n goes 1 on the first clock after reset_n deasserts. It is 0 only during CORE_RESET and asynchronous reset.
- IDLE, on header accept:
  - INST/DATA with count>0: latch address, count and target; go to WRITE.
  - INST/DATA with count=0: no writes; stay in IDLE.
  - RUN: clear timed_out and run_cycles; go to CORE_RESET.
  - reserved: pulse bad_cmd; stay in IDLE.
- WRITE, on each accepted word:
  - Next cycle: ext_write_address = current address, ext_write_data = word, exactly one strobe (per target) high for one cycle.
  - Address += 4, wrapping mod 2^ADDRESS_WIDTH.
  - Count -= 1; when the last word is accepted, return to IDLE.
  - Back-to-back words give one write per cycle; strobes are low in any cycle without an accept.
- CORE_RESET:
  - Hold core_reset_n=0 and run=0 for exactly CORE_RESET_CYCLES cycles.
  - Then raise core_reset_n; go to RUN, with run=1 from the next cycle.
- RUN:
  - run=1; run_cycles increments each cycle run is high.
  - Completion condition: halted==1, or (MAX_RUN_CYCLES≠0 and run_cycles==MAX_RUN_CYCLES−1 this cycle).
  - On completion: run=0 next cycle, done pulses once, timed_out=1 only if halted was still 0, return to IDLE.
  - Simultaneous halted and timeout: halted wins, timed_out=0.
- Sampling rule: halted is ignored while core_reset_n=0 and is sampled only while run=1.
- After completion, timed_out and run_cycles hold until the next RUN header.
- run_cycles wraps at 2^32, which only matters when the timeout is disabled.
- Asynchronous reset at any point returns to reset values immediately. A partial payload is abandoned; the host must resend the header.

Decomposition:
- Package shader_loader_pkg holds:
  - command-type constants: CMD_INST, CMD_DATA, CMD_RUN, CMD_RSVD;
  - header field bit positions;
  - state enum: IDLE, WRITE, CORE_RESET, RUN.
- One sub-module, run_timer: the run_cycles counter with a compare against MAX_RUN_CYCLES producing a timeout flag; clear/enable inputs.
- Stream parsing and the FSM stay in shader_loader.

Test Plan:
- INST header count=3 addr=0x0010, words A,B,C back-to-back -> strobe_inst high 3 consecutive cycles at 0x0010/0x0014/0x0018 with A/B/C; strobe_data never high; in_ready=1 throughout.
- DATA header count=2 addr=0xFFFC, in_valid gapped (1,0,1) -> writes at 0xFFFC then 0x0000; strobe low during the gap.
- RUN with CORE_RESET_CYCLES=2, model asserts halted 10 cycles after run rises -> core_reset_n low exactly 2 cycles; done pulses once; timed_out=0; run_cycles=10 (±1 registered-halted latency, fixed in bench); in_ready=0 until IDLE.
- RUN with MAX_RUN_CYCLES=50, halted never asserts -> run high exactly 50 cycles; done pulse; timed_out=1; run_cycles=50.
- Header 0xC0000000 -> bad_cmd pulse, no writes, in_ready stays 1. Count=0 INST header -> no strobe; next header accepted the following cycle.
- reset_n asserted mid-WRITE after 1 of 4 words -> outputs at reset values immediately; after release, a new INST header is accepted and writes from its own address.

Source files
------------

// File: rtl/shader_loader_pkg.sv
// Shared constants for the shader core loader: header field layout, command
// codes and controller states.
package shader_loader_pkg;

    localparam int CMD_MSB   = 31;
    localparam int CMD_LSB   = 30;
    localparam int COUNT_LSB = 16;
    localparam int ADDR_MSB  = 15;
    localparam int ADDR_LSB  = 0;

    typedef enum logic [1:0] {
        CMD_INST = 2'b00,
        CMD_DATA = 2'b01,
        CMD_RUN  = 2'b10,
        CMD_RSVD = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE      = 2'd1,
        CORE_RESET = 2'd2,
        RUN        = 2'd3
    } state_e;

endpackage

// File: rtl/shader_loader_run_timer.sv
// Run-cycle counter with a compare against the run timeout; a MAX_RUN_CYCLES
// of zero means the timeout never fires.
module run_timer
    import shader_loader_pkg::*;
#(
    parameter int unsigned MAX_RUN_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        enable,
    output logic [31:0] count,
    output logic        timeout
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + 32'd1;
    end

    // Fires during the last permitted run cycle so run drops after exactly MAX cycles.
    assign timeout = (MAX_RUN_CYCLES != 0) && (count == MAX_RUN_CYCLES - 32'd1);

endmodule

// File: rtl/shader_loader.sv
// Host-side loader: parses a command/payload word stream, writes the core's
// instruction/data RAMs, then resets and runs the core until halt or timeout.
module shader_loader
    import shader_loader_pkg::*;
#(
    parameter int          ADDRESS_WIDTH     = 16,
    parameter int          WORD_WIDTH        = 32,
    parameter int          COUNT_WIDTH       = 14,
    parameter int          CORE_RESET_CYCLES = 2,
    parameter int unsigned MAX_RUN_CYCLES    = 1000000
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [WORD_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    output logic                     core_reset_n,
    output logic                     run,
    input  logic                     halted,
    output logic [ADDRESS_WIDTH-1:0] ext_write_address,
    output logic [WORD_WIDTH-1:0]    ext_write_data,
    output logic                     ext_enable_write_inst,
    output logic                     ext_enable_write_data,
    output logic                     busy,
    output logic                     done,
    output logic                     timed_out,
    output logic                     bad_cmd,
    output logic [31:0]              run_cycles
);

    localparam int RC_W = (CORE_RESET_CYCLES > 1) ? $clog2(CORE_RESET_CYCLES) : 1;

    state_e                   state;
    logic [ADDRESS_WIDTH-1:0] cur_addr;
    logic [COUNT_WIDTH-1:0]   remaining;
    logic                     target_inst;
    logic [RC_W-1:0]          rst_cnt;

    cmd_e                     hdr_cmd;
    logic [COUNT_WIDTH-1:0]   hdr_count;
    logic [ADDRESS_WIDTH-1:0] hdr_addr;
    logic                     accept;
    logic                     timer_clear;
    logic                     timeout;

    assign hdr_cmd     = cmd_e'(in_data[CMD_MSB:CMD_LSB]);
    assign hdr_count   = in_data[COUNT_LSB +: COUNT_WIDTH];
    assign hdr_addr    = ADDRESS_WIDTH'({in_data[ADDR_MSB:ADDR_LSB+2], 2'b00});
    assign accept      = in_valid && in_ready;
    assign timer_clear = (state == IDLE) && accept && (hdr_cmd == CMD_RUN);

    run_timer #(.MAX_RUN_CYCLES(MAX_RUN_CYCLES)) u_run_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .enable  (run),
        .count   (run_cycles),
        .timeout (timeout)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= IDLE;
            cur_addr              <= '0;
            remaining             <= '0;
            target_inst           <= 1'b0;
            rst_cnt               <= '0;
            in_ready              <= 1'b1;
            core_reset_n          <= 1'b0;
            run                   <= 1'b0;
            ext_write_address     <= '0;
            ext_write_data        <= '0;
            ext_enable_write_inst <= 1'b0;
            ext_enable_write_data <= 1'b0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            timed_out             <= 1'b0;
            bad_cmd               <= 1'b0;
        end else begin
            // Pulses default low; core_reset_n is only pulled low inside CORE_RESET.
            ext_enable_write_inst <= 1'b0;
            ext_enable_write_data <= 1'b0;
            done                  <= 1'b0;
            bad_cmd               <= 1'b0;
            core_reset_n          <= 1'b1;

            case (state)
                IDLE: begin
                    if (accept) begin
                        case (hdr_cmd)
                            CMD_INST, CMD_DATA: begin
                                if (hdr_count != '0) begin
                                    cur_addr    <= hdr_addr;
                                    remaining   <= hdr_count;
                                    target_inst <= (hdr_cmd == CMD_INST);
                                    busy        <= 1'b1;
                                    state       <= WRITE;
                                end
                            end
                            CMD_RUN: begin
                                timed_out    <= 1'b0;
                                core_reset_n <= 1'b0;
                                rst_cnt      <= RC_W'(CORE_RESET_CYCLES - 1);
                                in_ready     <= 1'b0;
                                busy         <= 1'b1;
                                state        <= CORE_RESET;
                            end
                            CMD_RSVD: bad_cmd <= 1'b1;
                        endcase
                    end
                end

                WRITE: begin
                    if (accept) begin
                        ext_write_address     <= cur_addr;
                        ext_write_data        <= in_data;
                        ext_enable_write_inst <= target_inst;
                        ext_enable_write_data <= !target_inst;
                        cur_addr              <= cur_addr + ADDRESS_WIDTH'(4);
                        remaining             <= remaining - COUNT_WIDTH'(1);
                        if (remaining == COUNT_WIDTH'(1)) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end

                CORE_RESET: begin
                    if (rst_cnt == '0) begin
                        run   <= 1'b1;
                        state <= RUN;
                    end else begin
                        rst_cnt      <= rst_cnt - RC_W'(1);
                        core_reset_n <= 1'b0;
                    end
                end

                RUN: begin
                    // run is high throughout RUN, so halted is only looked at here.
                    if (halted || timeout) begin
                        run       <= 1'b0;
                        done      <= 1'b1;
                        timed_out <= !halted;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shader_loader.sv
// Self-checking bench for shader_loader: randomized payloads and run lengths
// checked against a queue-based model of the expected RAM writes and run outcome.
module tb_shader_loader;

    localparam int AW   = 16;
    localparam int WW   = 32;
    localparam int CRC  = 2;
    localparam int MAXR = 50;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [WW-1:0] in_data = '0;
    logic          halted = 1'b0;
    logic          in_ready, core_reset_n, run;
    logic [AW-1:0] ext_write_address;
    logic [WW-1:0] ext_write_data;
    logic          ext_enable_write_inst, ext_enable_write_data;
    logic          busy, done, timed_out, bad_cmd;
    logic [31:0]   run_cycles;

    shader_loader #(
        .ADDRESS_WIDTH(AW), .WORD_WIDTH(WW), .COUNT_WIDTH(14),
        .CORE_RESET_CYCLES(CRC), .MAX_RUN_CYCLES(MAXR)
    ) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .core_reset_n(core_reset_n), .run(run), .halted(halted),
        .ext_write_address(ext_write_address), .ext_write_data(ext_write_data),
        .ext_enable_write_inst(ext_enable_write_inst),
        .ext_enable_write_data(ext_enable_write_data),
        .busy(busy), .done(done), .timed_out(timed_out), .bad_cmd(bad_cmd),
        .run_cycles(run_cycles)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ready_low = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
        logic          inst;
        int            c;
    } wr_t;

    wr_t obs_q[$];
    wr_t exp_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    // Write monitor: records every strobe cycle and flags double strobes.
    always @(negedge clock) begin
        if (!in_ready) ready_low = ready_low + 1;
        if (ext_enable_write_inst || ext_enable_write_data) begin
            obs_q.push_back('{ext_write_address, ext_write_data, ext_enable_write_inst, cyc});
            n_cmp++;
            if (ext_enable_write_inst && ext_enable_write_data) begin
                n_bad++;
                $display("FAIL both_strobes: got inst=1 data=1, want exactly one");
            end
        end
    end

    function automatic logic [31:0] hdr(input logic [1:0] t, input int cnt, input logic [15:0] a);
        return {t, 14'(cnt), a};
    endfunction

    // Reference: a payload of n words lands at consecutive word addresses from
    // the header address with its low two bits cleared, modulo 2^16.
    function automatic void model_writes(input logic [1:0] t, input logic [15:0] a,
                                         input logic [31:0] w[$]);
        int base = int'(a) & 32'hFFFC;
        foreach (w[i])
            exp_q.push_back('{16'((base + 4 * i) % 65536), w[i], (t == 2'b00), 0});
    endfunction

    task automatic send(input logic [31:0] w);
        int t = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && t < 300) begin
            @(negedge clock);
            t++;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: in_ready=0 for %0d cycles, want 1", t);
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({core_reset_n, run, ext_enable_write_inst, ext_enable_write_data, busy,
             done, timed_out, bad_cmd, in_ready} !== 9'b000000001) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 000000001",
                     {core_reset_n, run, ext_enable_write_inst, ext_enable_write_data, busy,
                      done, timed_out, bad_cmd, in_ready});
        end
        n_cmp++;
        if ({ext_write_address, ext_write_data, run_cycles} !== '0) begin
            n_bad++;
            $display("FAIL reset_values: addr=%h data=%h run_cycles=%0d want 0",
                     ext_write_address, ext_write_data, run_cycles);
        end
        reset_n = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (core_reset_n !== 1'b1) begin
            n_bad++;
            $display("FAIL core_reset_release: got %b want 1", core_reset_n);
        end
    endtask

    task automatic test_inst_b2b();
        logic [31:0] w[$];
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 3; i++) w.push_back($urandom);
        model_writes(2'b00, 16'h0010, w);
        ready_low = 0;
        send(hdr(2'b00, 3, 16'h0010));
        foreach (w[i]) send(w[i]);
        repeat (3) @(negedge clock);
        n_cmp++;
        if (obs_q.size() != 3 || ready_low != 0) begin
            n_bad++;
            $display("FAIL inst_b2b_count: writes=%0d ready_low=%0d want 3/0",
                     obs_q.size(), ready_low);
        end else begin
            foreach (exp_q[i]) begin
                n_cmp++;
                if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data ||
                    obs_q[i].inst !== 1'b1 || obs_q[i].c != obs_q[0].c + i) begin
                    n_bad++;
                    $display("FAIL inst_b2b_write%0d: got a=%h d=%h inst=%b c+%0d want a=%h d=%h inst=1 c+%0d",
                             i, obs_q[i].addr, obs_q[i].data, obs_q[i].inst,
                             obs_q[i].c - obs_q[0].c, exp_q[i].addr, exp_q[i].data, i);
                end
            end
        end
    endtask

    task automatic test_data_wrap();
        logic [31:0] w[$];
        obs_q.delete(); exp_q.delete();
        w.push_back($urandom); w.push_back($urandom);
        model_writes(2'b01, 16'hFFFE, w);
        send(hdr(2'b01, 2, 16'hFFFE));
        send(w[0]);
        @(negedge clock);
        send(w[1]);
        repeat (3) @(negedge clock);
        n_cmp++;
        if (obs_q.size() != 2) begin
            n_bad++;
            $display("FAIL data_wrap_count: writes=%0d want 2", obs_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_cmp++;
                if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data ||
                    obs_q[i].inst !== 1'b0) begin
                    n_bad++;
                    $display("FAIL data_wrap_write%0d: got a=%h d=%h inst=%b want a=%h d=%h inst=0",
                             i, obs_q[i].addr, obs_q[i].data, obs_q[i].inst,
                             exp_q[i].addr, exp_q[i].data);
                end
            end
            n_cmp++;
            if (obs_q[1].c - obs_q[0].c != 2) begin
                n_bad++;
                $display("FAIL data_wrap_gap: got spacing %0d want 2", obs_q[1].c - obs_q[0].c);
            end
        end
    endtask

    task automatic test_random_writes();
        for (int it = 0; it < 6; it++) begin
            logic [31:0] w[$];
            logic [1:0]  t = 2'($urandom_range(0, 1));
            logic [15:0] a = 16'($urandom);
            int          n = $urandom_range(1, 6);
            obs_q.delete(); exp_q.delete();
            for (int i = 0; i < n; i++) w.push_back($urandom);
            model_writes(t, a, w);
            send(hdr(t, n, a));
            foreach (w[i]) begin
                repeat ($urandom_range(0, 2)) @(negedge clock);
                send(w[i]);
            end
            repeat (3) @(negedge clock);
            n_cmp++;
            if (obs_q.size() != exp_q.size()) begin
                n_bad++;
                $display("FAIL rand_write_count%0d: got %0d want %0d", it, obs_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    n_cmp++;
                    if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data ||
                        obs_q[i].inst !== exp_q[i].inst) begin
                        n_bad++;
                        $display("FAIL rand_write%0d_%0d: got a=%h d=%h i=%b want a=%h d=%h i=%b",
                                 it, i, obs_q[i].addr, obs_q[i].data, obs_q[i].inst,
                                 exp_q[i].addr, exp_q[i].data, exp_q[i].inst);
                    end
                end
            end
        end
    endtask

    task automatic test_bad_cmd();
        logic [31:0] w = $urandom;
        logic [15:0] a = 16'($urandom) & 16'hFFFC;
        obs_q.delete();
        ready_low = 0;
        send(32'hC000_0000 | (32'($urandom) & 32'h3FFF_FFFF));
        n_cmp++;
        if (bad_cmd !== 1'b1) begin
            n_bad++;
            $display("FAIL bad_cmd_pulse: got %b want 1", bad_cmd);
        end
        @(negedge clock);
        n_cmp++;
        if (bad_cmd !== 1'b0) begin
            n_bad++;
            $display("FAIL bad_cmd_single: got %b want 0", bad_cmd);
        end
        send(hdr(2'b00, 0, 16'h1234));
        send(hdr(2'b00, 1, a));
        send(w);
        repeat (3) @(negedge clock);
        n_cmp++;
        if (obs_q.size() != 1 || ready_low != 0) begin
            n_bad++;
            $display("FAIL count0_follow: writes=%0d ready_low=%0d want 1/0", obs_q.size(), ready_low);
        end else begin
            n_cmp++;
            if (obs_q[0].addr !== a || obs_q[0].data !== w || obs_q[0].inst !== 1'b1) begin
                n_bad++;
                $display("FAIL count0_follow_write: got a=%h d=%h want a=%h d=%h",
                         obs_q[0].addr, obs_q[0].data, a, w);
            end
        end
    endtask

    // hd: run cycle in which halted rises (0 = never); pre: assert halted during core reset.
    task automatic test_run(input int hd, input bit pre);
        int crn_low = 0, run_hi = 0, dn = 0, rdy_bad = 0, post = 0;
        int exp_hi  = (hd == 0 || hd > MAXR) ? MAXR : hd;
        bit exp_to  = (hd == 0 || hd > MAXR);
        obs_q.delete();
        send(hdr(2'b10, $urandom_range(0, 100), 16'($urandom)));
        for (int k = 0; k < 300 && post < 4; k++) begin
            if (!core_reset_n) crn_low++;
            if (run) begin
                run_hi++;
                halted = (hd != 0 && run_hi == hd);
            end else begin
                halted = pre && !core_reset_n;
            end
            if (done) dn++;
            if (busy && in_ready) rdy_bad++;
            if (dn > 0) post++;
            @(negedge clock);
        end
        halted = 1'b0;
        n_cmp++;
        if (crn_low != CRC) begin
            n_bad++;
            $display("FAIL run%0d_core_reset_len: got %0d want %0d", hd, crn_low, CRC);
        end
        n_cmp++;
        if (run_hi != exp_hi || dn != 1 || rdy_bad != 0) begin
            n_bad++;
            $display("FAIL run%0d_shape: run_hi=%0d done=%0d rdy_bad=%0d want %0d/1/0",
                     hd, run_hi, dn, rdy_bad, exp_hi);
        end
        n_cmp++;
        if (timed_out !== exp_to || run_cycles !== 32'(exp_hi) || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL run%0d_result: timed_out=%b run_cycles=%0d rdy=%b busy=%b want %b/%0d/1/0",
                     hd, timed_out, run_cycles, in_ready, busy, exp_to, exp_hi);
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL run%0d_no_writes: got %0d writes want 0", hd, obs_q.size());
        end
    endtask

    task automatic test_reset_mid_write();
        logic [15:0] a = 16'($urandom) & 16'hFFFC;
        logic [31:0] w[$];
        send(hdr(2'b00, 4, 16'h0200));
        send($urandom);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({ext_enable_write_inst, ext_enable_write_data, busy, core_reset_n, in_ready} !== 5'b00001 ||
            ext_write_address !== '0 || ext_write_data !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_write: strobes=%b%b busy=%b crn=%b rdy=%b a=%h d=%h want 0/0/0/0/1/0/0",
                     ext_enable_write_inst, ext_enable_write_data, busy, core_reset_n, in_ready,
                     ext_write_address, ext_write_data);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        obs_q.delete(); exp_q.delete();
        w.push_back($urandom); w.push_back($urandom);
        model_writes(2'b00, a, w);
        send(hdr(2'b00, 2, a));
        foreach (w[i]) send(w[i]);
        repeat (3) @(negedge clock);
        n_cmp++;
        if (obs_q.size() != 2) begin
            n_bad++;
            $display("FAIL after_reset_count: writes=%0d want 2", obs_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_cmp++;
                if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
                    n_bad++;
                    $display("FAIL after_reset_write%0d: got a=%h d=%h want a=%h d=%h",
                             i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_inst_b2b();
        test_data_wrap();
        test_random_writes();
        test_bad_cmd();
        test_run(10, 1'b0);
        test_run(0, 1'b0);
        test_run(MAXR, 1'b0);
        test_run(1, 1'b1);
        for (int i = 0; i < 3; i++) test_run($urandom_range(1, MAXR + 10), 1'($urandom_range(0, 1)));
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
